// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster timing with a clock-enable pixel rate.
// Optional frame counter: define VGA_TIMING_FRAME_CNT_EN to enable frame_cnt.
module vga_timing_gen #(
    parameter int CLK_DIV = 2,
    parameter int HPIXELS = 800,
    parameter int VLINES  = 521,
    parameter int HSP     = 128,
    parameter int VSP     = 2,
    parameter int HBP     = 144,
    parameter int HFP     = 784,
    parameter int VBP     = 31,
    parameter int VFP     = 511
) (
    input  logic       clk,
    input  logic       clr,
    output logic       pix_en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       vidon,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam logic [3:0]  DIV_MAX = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST  = 10'(HPIXELS - 1);
    localparam logic [9:0]  V_LAST  = 10'(VLINES - 1);
    // 11-bit bounds so a bound of 1024 still compares correctly
    localparam logic [10:0] HSP_W   = 11'(HSP);
    localparam logic [10:0] VSP_W   = 11'(VSP);
    localparam logic [10:0] HBP_W   = 11'(HBP);
    localparam logic [10:0] HFP_W   = 11'(HFP);
    localparam logic [10:0] VBP_W   = 11'(VBP);
    localparam logic [10:0] VFP_W   = 11'(VFP);

    logic [3:0] div_q, div_d;
    logic       pix_en_q, pix_en_d;
    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic       fs_q, fs_d;
    logic [10:0] hc_x, vc_x;

    // Next-state: divider, raster counters and frame wrap pulse; clr wins
    always_comb begin
        div_d    = (div_q == DIV_MAX) ? 4'd0 : div_q + 4'd1;
        pix_en_d = (div_q == DIV_MAX);
        hc_d     = hc_q;
        vc_d     = vc_q;
        fs_d     = 1'b0;
        if (pix_en_q) begin
            if (hc_q == H_LAST) begin
                hc_d = 10'd0;
                if (vc_q == V_LAST) begin
                    vc_d = 10'd0;
                    fs_d = 1'b1;
                end else begin
                    vc_d = vc_q + 10'd1;
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
        if (clr) begin
            div_d    = 4'd0;
            pix_en_d = 1'b0;
            hc_d     = 10'd0;
            vc_d     = 10'd0;
            fs_d     = 1'b0;
        end
    end

    // State registers; reset is folded into the _d logic above
    always_ff @(posedge clk) begin
        div_q    <= div_d;
        pix_en_q <= pix_en_d;
        hc_q     <= hc_d;
        vc_q     <= vc_d;
        fs_q     <= fs_d;
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] fc_q, fc_d;

    // Frame counter advances on the same edge frame_start rises
    always_comb begin
        fc_d = fs_d ? fc_q + 8'd1 : fc_q;
        if (clr) fc_d = 8'd0;
    end

    // Frame counter register
    always_ff @(posedge clk) begin
        fc_q <= fc_d;
    end

    assign frame_cnt = fc_q;
`else
    assign frame_cnt = 8'd0;
`endif

    assign hc_x = {1'b0, hc_q};
    assign vc_x = {1'b0, vc_q};

    assign pix_en      = pix_en_q;
    assign hc          = hc_q;
    assign vc          = vc_q;
    assign frame_start = fs_q;
    assign hsync       = ~(hc_x < HSP_W);
    assign vsync       = ~(vc_x < VSP_W);
    assign vidon       = (hc_x >= HBP_W) & (hc_x < HFP_W)
                       & (vc_x >= VBP_W) & (vc_x < VFP_W);

endmodule
